// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage adapter between the EX/MEM register and a
// word-addressed data memory. Loads are extracted and extended in the same
// cycle. Word stores go straight through. Sub-word stores take a one-cycle
// read-modify-write: the unit stalls for the read, then writes the merged word.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    Size,
  input  logic          Unsigned,
  input  logic          Flush,
  input  logic [AW-1:0] Address,
  input  logic [DW-1:0] WriteData,
  input  logic [DW-1:0] DM_ReadData,
  output logic          DM_MemRead,
  output logic          DM_MemWrite,
  output logic [AW-1:0] DM_Address,
  output logic [DW-1:0] DM_WriteData,
  output logic [DW-1:0] LoadData,
  output logic          Stall,
  output logic          Misaligned,
  output logic          Err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  // Only the low half of the store data can reach memory through the merge
  // path, because word stores never enter the RMW state.
  logic [15:0]     wdata_q, wdata_d;
  logic [DW-1:0]   merge_q, merge_d;
  logic            err_q, err_d;

  logic            req;
  logic            is_load;
  logic            misaligned_req;
  logic            active;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [DW-1:0]   load_ext;
  logic [DW-1:0]   rmw_word;
  logic [AW-1:0]   addr_aligned;

  assign req            = MemRead | MemWrite;
  // Simultaneous read and write is treated as a store.
  assign is_load        = MemRead & ~MemWrite;
  assign misaligned_req = req & (((Size == 2'b01) & Address[0]) |
                                 (Size[1] & (Address[1:0] != 2'b00)));
  // A request that the unit will actually carry out while it is idle.
  assign active         = (state_q == ST_IDLE) & ~Flush & req & ~misaligned_req;
  assign addr_aligned   = {Address[AW-1:2], 2'b00};

  // Pick the addressed byte or halfword out of the memory word and extend it.
  always_comb begin
    load_byte = DM_ReadData[8*Address[1:0] +: 8];
    load_half = Address[1] ? DM_ReadData[31:16] : DM_ReadData[15:0];
    load_ext  = DM_ReadData;
    case (Size)
      2'b00:   load_ext = Unsigned ? {24'd0, load_byte}
                                   : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_ext = Unsigned ? {16'd0, load_half}
                                   : {{16{load_half[15]}}, load_half};
      default: load_ext = DM_ReadData;
    endcase
  end

  // Per-lane merge of the latched store data into the word read in the
  // stall cycle. A byte store hits one lane; a half store hits a lane pair.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      assign lane_hit = (size_q == 2'b00) ? (addr_q[1:0] == 2'(gi))
                                          : (addr_q[1] == 1'(gi / 2));
      assign lane_src = (size_q == 2'b00) ? wdata_q[7:0]
                                          : wdata_q[8*(gi % 2) +: 8];
      assign rmw_word[8*gi +: 8] = lane_hit ? lane_src : merge_q[8*gi +: 8];
    end
  endgenerate

  // Next-state and output decode; every output defaults to inactive.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    merge_d      = merge_q;
    DM_MemRead   = 1'b0;
    DM_MemWrite  = 1'b0;
    DM_Address   = addr_aligned;
    DM_WriteData = '0;
    LoadData     = '0;
    Stall        = 1'b0;
    Misaligned   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        Misaligned = misaligned_req & ~Flush;
        if (active) begin
          if (is_load) begin
            DM_MemRead = 1'b1;
            LoadData   = load_ext;
          end else if (Size[1]) begin
            DM_MemWrite  = 1'b1;
            DM_WriteData = WriteData;
          end else begin
            // Sub-word store: read the old word now, write the merge next cycle.
            DM_MemRead = 1'b1;
            Stall      = 1'b1;
            merge_d    = DM_ReadData;
            addr_d     = Address;
            size_d     = Size;
            wdata_d    = WriteData[15:0];
            state_d    = ST_RMW;
          end
        end
      end
      ST_RMW: begin
        // Uses latched values only; a flush here cancels the write.
        DM_Address   = {addr_q[AW-1:2], 2'b00};
        DM_WriteData = rmw_word;
        DM_MemWrite  = ~Flush;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: any misaligned request that survives flush sets it.
  assign err_d = err_q | Misaligned;
  assign Err   = err_q;

  // State and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory in the MEM stage.
- Adds sub-word loads and stores: lb, lbu, lh, lhu, lw, sb, sh and sw.
- Loads are single-cycle extract plus sign or zero extension.
- Sub-word stores are a 2-cycle read-modify-write. The unit stalls the pipeline for 1 cycle and honours pipeline flush.
- Flags misaligned accesses and suppresses them.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width. Fixed at 32; four byte lanes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- MemRead  in  1  load request from EX/MEM.
- MemWrite  in  1  store request from EX/MEM.
- Size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- Unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Flush  in  1  pipeline flush; kills the current MEM-stage access.
- Address  in  AW  byte address.
- WriteData  in  DW  store data, right-justified.
- DM_ReadData  in  DW  word from data memory (combinational read).
- DM_MemRead  out  1  read enable to data memory.
- DM_MemWrite  out  1  write enable to data memory; memory writes on negedge.
- DM_Address  out  AW  word-aligned address, {addr[AW-1:2],2'b00}.
- DM_WriteData  out  DW  full word to write.
- LoadData  out  DW  extended load result to MEM/WB.
- Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM for this cycle.
- Misaligned  out  1  current request is misaligned (combinational).
- Err  out  1  sticky misalignment flag; cleared only by reset.

Behaviour:
- Lanes are little-endian. Byte k = bits [8k+7:8k], k = Address[1:0]. Half lane = Address[1].
- Misaligned request: (Size==01 && Address[0]) or (Size>=10 && Address[1:0]!=0), with MemRead or MemWrite high.
  - No DM_MemRead and no DM_MemWrite are issued; LoadData = 0; Misaligned = 1.
  - Err sets at the next posedge unless Flush is high.
- State machine: IDLE, RMW.
- IDLE, load (MemRead && !MemWrite):
  - DM_MemRead = 1, DM_Address = aligned Address.
  - LoadData = lane extracted from DM_ReadData, extended per Unsigned; word loads pass through.
  - Stall = 0; zero added latency.
- IDLE, word store: DM_MemWrite = 1, DM_WriteData = WriteData. Single cycle, Stall = 0.
- IDLE, aligned sub-word store, Flush = 0:
  - DM_MemRead = 1, Stall = 1.
  - At posedge: capture DM_ReadData into merge_q, and Address, Size and WriteData into regs; go to RMW.
- RMW:
  - DM_MemRead = 0, DM_MemWrite = 1, DM_Address from the latched address.
  - DM_WriteData = merge_q with the selected lane replaced by WriteData[7:0] or [15:0].
  - Stall = 0, so the pipeline advances at the end of this cycle. Next state IDLE.
- Flush:
  - In IDLE, Flush forces all DM_* enables, Stall and Misaligned to 0.
  - In RMW, Flush forces DM_MemWrite = 0 and returns to IDLE, so no write occurs.
- MemRead and MemWrite both high: treated as a store; the read is ignored and LoadData = 0.
- Upstream holds its inputs stable while Stall = 1. In RMW the unit uses only latched values.
- LoadData is 0 whenever no aligned load is active.
- Reset, including mid-RMW: state = IDLE, merge_q and latched regs = 0, Err = 0, no write issued.
- With idle inputs during reset all outputs are 0.

Test Plan:
- Load sign/zero extension: mem[0x10] = 0xAABBCCDD.
  - lb 0x11 -> LoadData 0xFFFFFFCC; lbu 0x11 -> 0x000000CC.
  - lh 0x12 -> 0xFFFFAABB; lw 0x10 -> 0xAABBCCDD.
  - Stall = 0 throughout.
- Sub-word store RMW, mem[0x10] = 0xAABBCCDD:
  - sb 0x12, data 0x55 -> Stall = 1 for exactly 1 cycle, DM_MemWrite in the next cycle, mem = 0xAA55CCDD.
  - Then sh 0x10, data 0x1234 -> mem = 0xAA551234.
- Word store: sw 0x20, data 0xDEADBEEF -> DM_MemWrite in the same cycle, Stall never asserted, mem[0x20] = 0xDEADBEEF.
- Misalignment: lw 0x13, then sh 0x21.
  - Both -> Misaligned = 1, DM_MemRead = DM_MemWrite = 0, LoadData = 0.
  - Err = 1 afterwards and stays 1 through later legal accesses until rst = 0.
- Flush during RMW: sb 0x11 issued, Flush = 1 in the RMW cycle -> DM_MemWrite stays 0, memory unchanged, state back to IDLE.
- Reset during RMW: rst low in the RMW cycle -> DM_MemWrite = 0 immediately, Err = 0.
  - After release, a following lw returns unmodified data.
